// File: rtl/controlador_semaforo_if.sv
// Handshake between the traffic-light sequencer and its external temporizador_m:
// a one-cycle trigger with a load value, answered by a busy flag.
interface controlador_semaforo_if;
  logic        Disparo;
  logic [27:0] Overflow;
  logic        Saida;

  modport master (output Disparo, output Overflow, input Saida);
  modport slave  (input Disparo, input Overflow, output Saida);
endinterface

// File: rtl/controlador_semaforo.sv
// Traffic-light sequencer: green / yellow / red+walk, each phase timed by re-arming
// the external timer and waiting for its busy flag to drop.
module controlador_semaforo #(
  parameter logic [27:0] T_VERDE    = 28'd250_000_000,
  parameter logic [27:0] T_AMARELO  = 28'd100_000_000,
  parameter logic [27:0] T_VERMELHO = 28'd200_000_000
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Pedestre,
  controlador_semaforo_if.master        tmr,
  output logic                          Verde,
  output logic                          Amarelo,
  output logic                          Vermelho,
  output logic                          Passe,
  output logic                          Pedido
);

  typedef enum logic [1:0] {VERDE, AMARELO, VERMELHO} fase_t;
  typedef enum logic [1:0] {INICIO, DISPARA, CONTANDO} sub_t;

  fase_t fase;
  sub_t  sub;
  logic  entra;
  fase_t prox;

  // The timer ignores a load of zero, so a zero-length phase is stretched to one cycle.
  function automatic logic [27:0] carga(input fase_t f);
    logic [27:0] t;
    case (f)
      VERDE:   t = T_VERDE;
      AMARELO: t = T_AMARELO;
      default: t = T_VERMELHO;
    endcase
    return (t == 28'd0) ? 28'd1 : t;
  endfunction

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    entra = 1'b0;
    prox  = VERDE;
    case (sub)
      INICIO:   entra = !tmr.Saida;
      CONTANDO: begin
        entra = !tmr.Saida;
        case (fase)
          VERDE:   prox = (Pedido || Pedestre) ? AMARELO : VERDE;
          AMARELO: prox = VERMELHO;
          default: prox = VERDE;
        endcase
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reads see pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fase         <= VERMELHO;
      sub          <= INICIO;
      tmr.Disparo  <= 1'b0;
      tmr.Overflow <= 28'd0;
      Pedido       <= 1'b0;
      Verde        <= 1'b0;
      Amarelo      <= 1'b0;
      Vermelho     <= 1'b1;
      Passe        <= 1'b0;
    end else begin
      tmr.Disparo <= 1'b0;

      // Entering red serves the request; a press in that same cycle is absorbed by it.
      if (entra && prox == VERMELHO) Pedido <= 1'b0;
      else if (Pedestre)             Pedido <= 1'b1;

      if (entra) begin
        fase         <= prox;
        sub          <= DISPARA;
        tmr.Disparo  <= 1'b1;
        tmr.Overflow <= carga(prox);
        Verde        <= (prox == VERDE);
        Amarelo      <= (prox == AMARELO);
        Vermelho     <= (prox == VERMELHO);
        Passe        <= (prox == VERMELHO);
      end else if (sub == DISPARA) begin
        sub <= CONTANDO;
      end
    end
  end

endmodule

// File: doc/controlador_semaforo.md
Name: controlador_semaforo

Overview:
Traffic-light sequencer that owns one temporizador_m instance, which sits outside this block.
- Arms the timer with a per-phase duration and waits for its Saida to fall, then advances the phase.
- Phases: green, yellow, red/pedestrian-walk.
- Green holds by re-arming the timer repeatedly until a latched pedestrian request is pending.

Parameters:
T_VERDE, 28'd250_000_000, green window length in clock cycles (5 s at 50 MHz)
T_AMARELO, 28'd100_000_000, yellow length in clock cycles (2 s)
T_VERMELHO, 28'd200_000_000, red/walk length in clock cycles (4 s)

Ports:
Clk  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-high reset
Pedestre  in  1  pedestrian button, level, synchronous to Clk
Saida  in  1  timer busy flag from temporizador_m (1 while count != 0)
Disparo  out  1  timer trigger; one-cycle pulse
Overflow  out  28  timer load value; valid while Disparo=1
Verde  out  1  green lamp
Amarelo  out  1  yellow lamp
Vermelho  out  1  red lamp
Passe  out  1  pedestrian walk lamp
Pedido  out  1  latched pedestrian request

Behaviour:
- One clock; reset is synchronous and active-high: Clk is the clock, Reset the reset.
- State is fase {VERDE, AMARELO, VERMELHO} × sub-state {INICIO, DISPARA, CONTANDO}.
- Reset values:
  - fase=VERMELHO, sub=INICIO, Pedido=0, Disparo=0, Overflow=0.
  - Vermelho=1, Verde=0, Amarelo=0, Passe=0 (all-red, no walk).
- Reset does not reach the timer, which may still be counting.
- INICIO: hold all-red and Disparo=0 until Saida=0. Then fase=VERDE, sub=DISPARA.
- DISPARA (exactly one cycle):
  - Disparo=1 and Overflow=T_fase; next sub=CONTANDO.
  - A parameter value of 0 is driven as 1 (timer ignores 0).
- CONTANDO: Disparo=0, Overflow held. Stay while Saida=1. On the first cycle with Saida=0:
  - VERDE, and (Pedido | Pedestre)=1 -> AMARELO/DISPARA.
  - VERDE otherwise -> VERDE/DISPARA (re-arm, green holds).
  - AMARELO -> VERMELHO/DISPARA.
  - VERMELHO -> VERDE/DISPARA.
- Timing contract with the timer:
  - Timer loads on the edge that ends DISPARA; Saida is already 1 in the first CONTANDO cycle.
  - Each phase occupies T+2 cycles: DISPARA + T counting + one Saida=0 detect cycle.
- Disparo is never high two consecutive cycles, so the timer cannot auto-reload.
- Lamps are decoded from fase, registered, and change on the edge entering the new phase's DISPARA.
  - VERDE: Verde=1. AMARELO: Amarelo=1. VERMELHO: Vermelho=1, Passe=1.
  - INICIO: Vermelho=1, Passe=0.
  - Exactly one vehicle lamp is high at all times.
- Pedido:
  - Set by Pedestre=1 in any cycle.
  - Cleared on the edge entering VERMELHO/DISPARA; Pedestre in that same cycle is dropped (request being served).
  - Pedestre during VERMELHO after entry sets Pedido, and it is served after the next green window.
- A request arriving mid-green never shortens the current green window; it takes effect at that window's end.
- Reset mid-operation:
  - Immediate return to all-red.
  - No Disparo until Saida=0 is observed, even if the timer runs ~2^28 cycles.
- Saida=0 in the first CONTANDO cycle (timer malfunction) is treated as expiry: phase advances normally.

Test Plan:
1. Params 5/2/3; Reset 2 cycles, Saida=0, Pedestre=0 -> Disparo pulse with Overflow=5 on cycle 1 after reset, repeated every 7 cycles; Verde=1 throughout; Amarelo and Passe never 1.
2. Single-cycle Pedestre 3 cycles into green -> Pedido=1 next cycle; green window completes (7 cycles); then Amarelo for 4 cycles with Overflow=2; then Vermelho+Passe for 5 cycles with Overflow=3; Pedido=0 from red entry; back to Verde with Overflow=5.
3. Pedestre asserted only on the green detect cycle (Saida=0) -> next phase is AMARELO, not green re-arm.
4. Pedestre held high through the red-entry cycle and released -> Pedido=0 after entry. Pedestre pulsed in mid-red -> Pedido=1; after the following 7-cycle green, yellow starts.
5. Reset asserted mid-yellow with a behavioural timer still at count 40 -> all-red next cycle, Passe=0, no Disparo for 40 cycles; Disparo with Overflow=5 on the first cycle after Saida falls.
6. Whole run with the real temporizador_m attached -> assert Disparo never high on 2 consecutive cycles, exactly one vehicle lamp high, Passe=1 only with Vermelho=1.
